// File: rtl/trap_ctrl.sv
// trap_ctrl: sequencer that owns the machine-mode CSR file port.
// It serves three requesters: trap entry, MRET return and pipeline CSR
// instructions. Trap entry and MRET run multi-cycle CSR read/write
// sequences and finish with a PC redirect to fetch.
module trap_ctrl #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trap_req,
  input  logic [XLEN-1:0]   trap_pc,
  input  logic [XLEN-1:0]   trap_cause,
  output logic              trap_ack,
  input  logic              mret_req,
  output logic              mret_ack,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  input  logic              csr_req,
  input  logic [1:0]        csr_op,
  input  logic [ADDR_W-1:0] csr_addr_in,
  input  logic [XLEN-1:0]   csr_wdata_in,
  output logic              csr_done,
  output logic [XLEN-1:0]   csr_rdata_out,
  output logic              busy,
  output logic              csr_write,
  output logic              csr_read,
  output logic [ADDR_W-1:0] csr_addr,
  output logic [XLEN-1:0]   csr_write_data,
  input  logic [XLEN-1:0]   csr_read_data
);

  localparam logic [ADDR_W-1:0] A_MSTATUS = ADDR_W'(12'h300);
  localparam logic [ADDR_W-1:0] A_MTVEC   = ADDR_W'(12'h305);
  localparam logic [ADDR_W-1:0] A_MEPC    = ADDR_W'(12'h341);
  localparam logic [ADDR_W-1:0] A_MCAUSE  = ADDR_W'(12'h342);

  typedef enum logic [3:0] {
    IDLE, T_EPC, T_CAUSE, T_RSTAT, T_WSTAT, T_RTVEC,
    M_RSTAT, M_WSTAT, M_REPC, P_ACC, DONE
  } state_t;

  state_t            state;
  logic [XLEN-1:0]   cause_reg;
  logic [1:0]        op_reg;
  logic [XLEN-1:0]   wdata_reg;
  logic [XLEN-1:0]   wdata_out_reg;

  logic [XLEN-1:0]   trap_stat_new;
  logic [XLEN-1:0]   mret_stat_new;
  logic [XLEN-1:0]   tvec_base;
  logic [XLEN-1:0]   vec_off;
  logic [XLEN-1:0]   trap_target;
  logic [XLEN-1:0]   pacc_new;

  // RS/RC with a zero operand must not produce a write side effect
  function automatic logic pacc_we(input logic [1:0] op, input logic [XLEN-1:0] wd);
    return (op == 2'b01) || (op[1] && (wd != '0));
  endfunction

  // Derived values computed from the CSR file's combinational read data
  always_comb begin
    trap_stat_new        = csr_read_data;
    trap_stat_new[7]     = csr_read_data[3];
    trap_stat_new[3]     = 1'b0;
    trap_stat_new[12:11] = 2'b11;

    mret_stat_new        = csr_read_data;
    mret_stat_new[3]     = csr_read_data[7];
    mret_stat_new[7]     = 1'b1;
    mret_stat_new[12:11] = 2'b11;

    tvec_base = {csr_read_data[XLEN-1:2], 2'b00};
    vec_off   = {1'b0, cause_reg[XLEN-2:0]} << 2;
    if (csr_read_data[1:0] == 2'b01 && cause_reg[XLEN-1])
      trap_target = tvec_base + vec_off;
    else
      trap_target = tvec_base;

    case (op_reg)
      2'b01:   pacc_new = wdata_reg;
      2'b10:   pacc_new = csr_read_data | wdata_reg;
      2'b11:   pacc_new = csr_read_data & ~wdata_reg;
      default: pacc_new = csr_read_data;
    endcase
  end

  // The CSR instruction's write data depends on the old value read in the
  // same cycle, so it cannot be registered; every other cycle uses the
  // registered write data.
  assign csr_write_data = (state == P_ACC) ? (csr_write ? pacc_new : '0) : wdata_out_reg;

  // Main sequencer: outputs are registered on the edge entering each state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cause_reg      <= '0;
      op_reg         <= '0;
      wdata_reg      <= '0;
      wdata_out_reg  <= '0;
      trap_ack       <= 1'b0;
      mret_ack       <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      csr_done       <= 1'b0;
      csr_rdata_out  <= '0;
      busy           <= 1'b0;
      csr_write      <= 1'b0;
      csr_read       <= 1'b0;
      csr_addr       <= '0;
    end else begin
      trap_ack       <= 1'b0;
      mret_ack       <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      csr_done       <= 1'b0;
      csr_rdata_out  <= '0;
      csr_write      <= 1'b0;
      csr_read       <= 1'b0;
      csr_addr       <= '0;
      wdata_out_reg  <= '0;
      busy           <= 1'b1;
      case (state)
        IDLE: begin
          if (trap_req) begin
            cause_reg     <= trap_cause;
            state         <= T_EPC;
            csr_write     <= 1'b1;
            csr_addr      <= A_MEPC;
            wdata_out_reg <= trap_pc & ~XLEN'(3);
          end else if (mret_req) begin
            state    <= M_RSTAT;
            csr_read <= 1'b1;
            csr_addr <= A_MSTATUS;
          end else if (csr_req) begin
            op_reg    <= csr_op;
            wdata_reg <= csr_wdata_in;
            state     <= P_ACC;
            csr_read  <= 1'b1;
            csr_write <= pacc_we(csr_op, csr_wdata_in);
            csr_addr  <= csr_addr_in;
          end else begin
            busy <= 1'b0;
          end
        end
        T_EPC: begin
          state         <= T_CAUSE;
          csr_write     <= 1'b1;
          csr_addr      <= A_MCAUSE;
          wdata_out_reg <= cause_reg;
        end
        T_CAUSE: begin
          state    <= T_RSTAT;
          csr_read <= 1'b1;
          csr_addr <= A_MSTATUS;
        end
        T_RSTAT: begin
          state         <= T_WSTAT;
          csr_write     <= 1'b1;
          csr_addr      <= A_MSTATUS;
          wdata_out_reg <= trap_stat_new;
        end
        T_WSTAT: begin
          state    <= T_RTVEC;
          csr_read <= 1'b1;
          csr_addr <= A_MTVEC;
        end
        T_RTVEC: begin
          state          <= DONE;
          trap_ack       <= 1'b1;
          redirect_valid <= 1'b1;
          redirect_pc    <= trap_target;
        end
        M_RSTAT: begin
          state         <= M_WSTAT;
          csr_write     <= 1'b1;
          csr_addr      <= A_MSTATUS;
          wdata_out_reg <= mret_stat_new;
        end
        M_WSTAT: begin
          state    <= M_REPC;
          csr_read <= 1'b1;
          csr_addr <= A_MEPC;
        end
        M_REPC: begin
          state          <= DONE;
          mret_ack       <= 1'b1;
          redirect_valid <= 1'b1;
          redirect_pc    <= csr_read_data & ~XLEN'(3);
        end
        P_ACC: begin
          state         <= DONE;
          csr_done      <= 1'b1;
          csr_rdata_out <= csr_read_data;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed and randomized checks of trap_ctrl against a
// CSR-file model and a specification-level reference model.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trap_req = 1'b0;
  logic [31:0] trap_pc = '0;
  logic [31:0] trap_cause = '0;
  logic        trap_ack;
  logic        mret_req = 1'b0;
  logic        mret_ack;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        csr_req = 1'b0;
  logic [1:0]  csr_op = '0;
  logic [11:0] csr_addr_in = '0;
  logic [31:0] csr_wdata_in = '0;
  logic        csr_done;
  logic [31:0] csr_rdata_out;
  logic        busy;
  logic        csr_write;
  logic        csr_read;
  logic [11:0] csr_addr;
  logic [31:0] csr_write_data;
  logic [31:0] csr_read_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trap_ctrl #(.XLEN(32), .ADDR_W(12)) dut (
    .clk(clk), .rst(rst),
    .trap_req(trap_req), .trap_pc(trap_pc), .trap_cause(trap_cause), .trap_ack(trap_ack),
    .mret_req(mret_req), .mret_ack(mret_ack),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .csr_req(csr_req), .csr_op(csr_op), .csr_addr_in(csr_addr_in), .csr_wdata_in(csr_wdata_in),
    .csr_done(csr_done), .csr_rdata_out(csr_rdata_out), .busy(busy),
    .csr_write(csr_write), .csr_read(csr_read), .csr_addr(csr_addr),
    .csr_write_data(csr_write_data), .csr_read_data(csr_read_data)
  );

  // CSR file model: combinational read, write on rising edge; a side port preloads it
  logic [31:0] csr_mem [4096];
  logic        pre_we = 1'b0;
  logic [11:0] pre_addr = '0;
  logic [31:0] pre_data = '0;
  int          wr_count = 0;
  int          viol = 0;

  assign csr_read_data = csr_mem[csr_addr];

  always @(posedge clk) begin
    if (csr_write) begin
      csr_mem[csr_addr] <= csr_write_data;
      wr_count <= wr_count + 1;
    end else if (pre_we) begin
      csr_mem[pre_addr] <= pre_data;
    end
  end

  // Bus hygiene: address/data must be zero when their enable is low
  always @(negedge clk) begin
    if (!rst) begin
      if (!csr_write && csr_write_data != 32'h0) viol++;
      if (!csr_write && !csr_read && csr_addr != 12'h0) viol++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [31:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    tick();
    pre_we   = 1'b0;
  endtask

  // Reference model: architectural effects stated as plain arithmetic
  function automatic logic [31:0] m_trap_stat(input logic [31:0] s);
    return (s & ~32'h0000_1888) | 32'h0000_1800 | (s[3] ? 32'h80 : 32'h0);
  endfunction

  function automatic logic [31:0] m_mret_stat(input logic [31:0] s);
    return (s & ~32'h0000_1888) | 32'h0000_1880 | (s[7] ? 32'h8 : 32'h0);
  endfunction

  function automatic logic [31:0] m_target(input logic [31:0] tvec, input logic [31:0] cause);
    logic [31:0] base;
    logic [31:0] code;
    base = tvec - (tvec % 4);
    code = cause % 32'h8000_0000;
    if ((tvec % 4) == 1 && cause >= 32'h8000_0000) return base + code * 4;
    return base;
  endfunction

  function automatic logic [31:0] m_csr(input logic [1:0] op, input logic [31:0] old, input logic [31:0] w);
    case (op)
      2'd1:    return w;
      2'd2:    return old | w;
      2'd3:    return old & ~w;
      default: return old;
    endcase
  endfunction

  task automatic do_trap(input logic [31:0] pc, input logic [31:0] cause,
                         input logic [31:0] tvec, input logic [31:0] stat);
    int n;
    poke(12'h305, tvec);
    poke(12'h300, stat);
    trap_pc = pc;
    trap_cause = cause;
    trap_req = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!trap_ack && n < 20);
    chk("trap_latency", 32'(n), 32'd6);
    chk("trap_redirect_valid", 32'(redirect_valid), 32'd1);
    chk("trap_redirect_pc", redirect_pc, m_target(tvec, cause));
    trap_req = 1'b0;
    tick();
    chk("trap_ack_pulse", 32'(trap_ack), 32'd0);
    chk("trap_busy_idle", 32'(busy), 32'd0);
    chk("trap_mepc", csr_mem[12'h341], pc & ~32'h3);
    chk("trap_mcause", csr_mem[12'h342], cause);
    chk("trap_mstatus", csr_mem[12'h300], m_trap_stat(stat));
    $display("trap pc=%08h cause=%08h tvec=%08h -> redirect %08h", pc, cause, tvec, m_target(tvec, cause));
  endtask

  task automatic do_mret(input logic [31:0] stat, input logic [31:0] mepc);
    int n;
    poke(12'h300, stat);
    poke(12'h341, mepc);
    mret_req = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!mret_ack && n < 20);
    chk("mret_latency", 32'(n), 32'd4);
    chk("mret_redirect_valid", 32'(redirect_valid), 32'd1);
    chk("mret_redirect_pc", redirect_pc, mepc & ~32'h3);
    mret_req = 1'b0;
    tick();
    chk("mret_busy_idle", 32'(busy), 32'd0);
    chk("mret_mstatus", csr_mem[12'h300], m_mret_stat(stat));
    $display("mret mstatus=%08h mepc=%08h -> redirect %08h", stat, mepc, mepc & ~32'h3);
  endtask

  task automatic do_csr(input logic [11:0] a, input logic [1:0] op,
                        input logic [31:0] w, input logic [31:0] old);
    int n;
    int wc0;
    int exp_wr;
    poke(a, old);
    wc0 = wr_count;
    csr_addr_in = a;
    csr_op = op;
    csr_wdata_in = w;
    csr_req = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!csr_done && n < 20);
    chk("csr_latency", 32'(n), 32'd2);
    chk("csr_rdata", csr_rdata_out, old);
    csr_req = 1'b0;
    tick();
    exp_wr = (op == 2'd1 || (op >= 2'd2 && w != 32'h0)) ? 1 : 0;
    chk("csr_value", csr_mem[a], m_csr(op, old, w));
    chk("csr_write_count", 32'(wr_count - wc0), 32'(exp_wr));
    $display("csr addr=%03h op=%0d wdata=%08h old=%08h -> new %08h", a, op, w, old, m_csr(op, old, w));
  endtask

  initial begin
    int t_cyc, m_cyc, c_cyc, t_cnt, m_cnt, c_cnt, acks;
    logic [31:0] m_pc;

    // Reset state
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_csr_write", 32'(csr_write), 32'd0);
    chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    rst = 1'b0;
    tick();

    // Directed scenarios
    do_trap(32'h100, 32'h2, 32'h8000_0000, 32'h8);
    do_trap(32'h100, 32'h8000_0007, 32'h8000_0001, 32'h8);
    do_trap(32'h100, 32'h7, 32'h8000_0001, 32'h8);
    do_trap(32'h203, 32'h8000_0010, 32'hFFFF_FFF1, 32'h0);
    do_trap(32'h400, 32'h8000_0003, 32'h1000_0002, 32'h88);
    do_mret(32'h1880, 32'h104);
    do_csr(12'h340, 2'd2, 32'h0F, 32'hF0);
    do_csr(12'h340, 2'd3, 32'h0, 32'hFF);
    do_csr(12'h340, 2'd0, 32'h55, 32'hAB);

    // All three requesters at once: trap, then MRET, then CSR
    poke(12'h305, 32'h8000_0000);
    poke(12'h300, 32'h8);
    poke(12'h340, 32'hF0);
    trap_pc = 32'h100; trap_cause = 32'h2;
    csr_addr_in = 12'h340; csr_op = 2'd2; csr_wdata_in = 32'h0F;
    trap_req = 1'b1; mret_req = 1'b1; csr_req = 1'b1;
    t_cyc = 0; m_cyc = 0; c_cyc = 0; t_cnt = 0; m_cnt = 0; c_cnt = 0; m_pc = '0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (trap_ack) begin t_cyc = c; t_cnt++; trap_req = 1'b0; end
      if (mret_ack) begin m_cyc = c; m_cnt++; m_pc = redirect_pc; mret_req = 1'b0; end
      if (csr_done) begin c_cyc = c; c_cnt++; csr_req = 1'b0; end
    end
    chk("arb_trap_cycle", 32'(t_cyc), 32'd6);
    chk("arb_mret_cycle", 32'(m_cyc), 32'd11);
    chk("arb_csr_cycle", 32'(c_cyc), 32'd14);
    chk("arb_pulse_counts", 32'(t_cnt * 100 + m_cnt * 10 + c_cnt), 32'd111);
    chk("arb_mret_pc", m_pc, 32'h100);
    chk("arb_mstatus", csr_mem[12'h300], m_mret_stat(m_trap_stat(32'h8)));
    chk("arb_csr_value", csr_mem[12'h340], 32'hFF);
    $display("arbitration trap@%0d mret@%0d csr@%0d", t_cyc, m_cyc, c_cyc);

    // Reset in the middle of a trap sequence
    poke(12'h341, 32'hDEAD_0000);
    poke(12'h342, 32'h55);
    poke(12'h300, 32'h8);
    trap_pc = 32'h200; trap_cause = 32'hB; trap_req = 1'b1;
    tick(); tick(); tick();
    chk("abort_in_rstat", 32'(csr_read), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_outputs", {26'h0, csr_read, csr_write, busy, trap_ack, redirect_valid, 1'b0} | 32'(csr_addr), 32'h0);
    trap_req = 1'b0;
    tick();
    rst = 1'b0;
    acks = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (trap_ack || redirect_valid) acks++;
    end
    chk("abort_no_ack", 32'(acks), 32'd0);
    chk("abort_mepc", csr_mem[12'h341], 32'h200);
    chk("abort_mcause", csr_mem[12'h342], 32'hB);
    chk("abort_mstatus", csr_mem[12'h300], 32'h8);
    $display("reset abort in T_RSTAT: acks=%0d", acks);

    // Randomized transactions
    for (int i = 0; i < 40; i++) begin
      int kind;
      logic [31:0] w;
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        do_trap($urandom, ($urandom_range(0, 1) == 1) ? ($urandom | 32'h8000_0000) : ($urandom & 32'h7FFF_FFFF),
                $urandom, $urandom);
      end else if (kind == 1) begin
        do_mret($urandom, $urandom);
      end else begin
        w = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
        do_csr(12'($urandom_range(0, 4095)), 2'($urandom_range(0, 3)), w, $urandom);
      end
    end

    chk("bus_hygiene", 32'(viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
